// File: rtl/cs_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU function codes,
// sequencer state encoding and the instruction-width derivation.
// Optional feature macro used by the top level: SINGLE_STEP_EN.
package cs_pkg;

    // Opcode field values (upper four bits of the instruction word)
    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_MOV  = 4'd1;
    localparam logic [3:0] OPC_INC  = 4'd2;
    localparam logic [3:0] OPC_ADD  = 4'd3;
    localparam logic [3:0] OPC_SUB  = 4'd4;
    localparam logic [3:0] OPC_AND  = 4'd5;
    localparam logic [3:0] OPC_OR   = 4'd6;
    localparam logic [3:0] OPC_XOR  = 4'd7;
    localparam logic [3:0] OPC_NOT  = 4'd8;
    localparam logic [3:0] OPC_LDI  = 4'd9;
    localparam logic [3:0] OPC_LD   = 4'd10;
    localparam logic [3:0] OPC_ST   = 4'd11;
    localparam logic [3:0] OPC_BRZ  = 4'd12;
    localparam logic [3:0] OPC_BRN  = 4'd13;
    localparam logic [3:0] OPC_JMP  = 4'd14;
    localparam logic [3:0] OPC_HALT = 4'd15;

    // ALU function-select codes of the existing datapath
    localparam logic [3:0] FS_MOVA  = 4'b0000;
    localparam logic [3:0] FS_INC   = 4'b0001;
    localparam logic [3:0] FS_ADD   = 4'b0010;
    localparam logic [3:0] FS_SUB   = 4'b0101;
    localparam logic [3:0] FS_PASSB = 4'b0111;
    localparam logic [3:0] FS_AND   = 4'b1000;
    localparam logic [3:0] FS_OR    = 4'b1001;
    localparam logic [3:0] FS_XOR   = 4'b1010;
    localparam logic [3:0] FS_NOT   = 4'b1011;
    localparam logic [3:0] FS_ZERO  = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Instruction word is {OPC[3:0], DR, SA, SB}
    function automatic int instr_width(input int reg_aw);
        return 4 + 3 * reg_aw;
    endfunction

endpackage

// File: rtl/cs_decoder.sv
// Combinational opcode decoder: produces the datapath write/select controls.
// Every control is forced low unless the sequencer is in its execute state,
// so no register or memory write can be issued from any other state.
module cs_decoder
    import cs_pkg::*;
(
    input  logic [3:0] opc,
    input  logic       exec,
    output logic       mb,
    output logic       md,
    output logic       rw,
    output logic       mw,
    output logic [3:0] fs
);

    // Map opcode to controls, gated by the execute qualifier
    always_comb begin
        mb = 1'b0;
        md = 1'b0;
        rw = 1'b0;
        mw = 1'b0;
        fs = FS_ZERO;
        if (exec) begin
            case (opc)
                OPC_MOV: begin fs = FS_MOVA;  rw = 1'b1; end
                OPC_INC: begin fs = FS_INC;   rw = 1'b1; end
                OPC_ADD: begin fs = FS_ADD;   rw = 1'b1; end
                OPC_SUB: begin fs = FS_SUB;   rw = 1'b1; end
                OPC_AND: begin fs = FS_AND;   rw = 1'b1; end
                OPC_OR:  begin fs = FS_OR;    rw = 1'b1; end
                OPC_XOR: begin fs = FS_XOR;   rw = 1'b1; end
                OPC_NOT: begin fs = FS_NOT;   rw = 1'b1; end
                OPC_LDI: begin fs = FS_PASSB; mb = 1'b1; rw = 1'b1; end
                OPC_LD:  begin md = 1'b1;     rw = 1'b1; end
                OPC_ST:  begin mw = 1'b1; end
                default: begin fs = FS_ZERO; end
            endcase
        end else begin
            fs = FS_ZERO;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: owns PC, instruction register and the
// IDLE/FETCH/DECODE/EXEC/HALT sequencer, and drives the datapath controls.
// Optional feature: define SINGLE_STEP_EN to add the 'step' input; the FSM
// then parks in IDLE after every instruction and resumes on step.
module control_sequencer
    import cs_pkg::*;
#(
    parameter  int REG_AW  = 2,
    parameter  int DATA_W  = 4,
    parameter  int PC_W    = 4,
    localparam int INSTR_W = instr_width(REG_AW)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [DATA_W-1:0]  AData,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [REG_AW-1:0]  DA,
    output logic [REG_AW-1:0]  AA,
    output logic [REG_AW-1:0]  BA,
    output logic               MB,
    output logic               MD,
    output logic               RW,
    output logic               MW,
    output logic [3:0]         FS,
    output logic [DATA_W-1:0]  Constant,
    output logic [PC_W-1:0]    PC,
    output logic               halted
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 mb_q, md_q, rw_q, mw_q, halted_q;
    logic [3:0]           fs_q;
    logic                 mb_d, md_d, rw_d, mw_d;
    logic [3:0]           fs_d;

    logic [3:0]           opc;
    logic [REG_AW-1:0]    dr, sa, sb;
    logic signed [2*REG_AW-1:0] br_off_raw;
    logic [PC_W-1:0]      br_off, pc_inc, jmp_tgt;

    assign opc        = ir_q[INSTR_W-1 -: 4];
    assign dr         = ir_q[3*REG_AW-1 -: REG_AW];
    assign sa         = ir_q[2*REG_AW-1 -: REG_AW];
    assign sb         = ir_q[REG_AW-1:0];
    assign br_off_raw = {dr, sb};
    // Signed cast sign-extends (or truncates) the offset to PC width
    assign br_off     = PC_W'(br_off_raw);
    assign pc_inc     = pc_q + PC_ONE;
    // Unsigned cast zero-extends (or truncates) the A-bus to PC width
    assign jmp_tgt    = PC_W'(AData);

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign DA        = dr;
    assign AA        = sa;
    assign BA        = sb;
    assign Constant  = DATA_W'(sb);
    assign MB        = mb_q;
    assign MD        = md_q;
    assign RW        = rw_q;
    assign MW        = mw_q;
    assign FS        = fs_q;
    assign halted    = halted_q;

    // Controls are decoded from the next IR/state so they can be registered
    cs_decoder u_dec (
        .opc  (ir_d[INSTR_W-1 -: 4]),
        .exec (state_d == ST_EXEC),
        .mb   (mb_d),
        .md   (md_d),
        .rw   (rw_d),
        .mw   (mw_d),
        .fs   (fs_d)
    );

    // Next-state, next-PC and IR-load logic of the sequencer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = {PC_W{1'b0}};
`ifdef SINGLE_STEP_EN
                end else if (step) begin
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opc)
                    OPC_BRZ: begin
                        if (AData == {DATA_W{1'b0}}) pc_d = pc_q + br_off;
                        else                         pc_d = pc_inc;
                    end
                    OPC_BRN: begin
                        if (AData[DATA_W-1]) pc_d = pc_q + br_off;
                        else                 pc_d = pc_inc;
                    end
                    OPC_JMP:  pc_d = jmp_tgt;
                    OPC_HALT: pc_d = pc_q;
                    default:  pc_d = pc_inc;
                endcase
                if (opc == OPC_HALT) begin
                    state_d = ST_HALT;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_d = ST_IDLE;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC, IR and registered control outputs with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pc_q     <= {PC_W{1'b0}};
            ir_q     <= {INSTR_W{1'b0}};
            mb_q     <= 1'b0;
            md_q     <= 1'b0;
            rw_q     <= 1'b0;
            mw_q     <= 1'b0;
            fs_q     <= 4'b0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mb_q     <= mb_d;
            md_q     <= md_d;
            rw_q     <= rw_d;
            mw_q     <= mw_d;
            fs_q     <= fs_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer (default parameters).
// Expected controls/PC are queued when an instruction is placed in the ROM
// and popped when the DUT reaches its execute cycle.
module tb_control_sequencer;
    import cs_pkg::*;

    localparam int REG_AW  = 2;
    localparam int DATA_W  = 4;
    localparam int PC_W    = 4;
    localparam int INSTR_W = 4 + 3 * REG_AW;

    logic               CLK = 1'b0;
    logic               RST;
    logic               start;
`ifdef SINGLE_STEP_EN
    logic               step;
`endif
    logic [DATA_W-1:0]  AData;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [REG_AW-1:0]  DA, AA, BA;
    logic               MB, MD, RW, MW;
    logic [3:0]         FS;
    logic [DATA_W-1:0]  Constant;
    logic [PC_W-1:0]    PC;
    logic               halted;

    logic [INSTR_W-1:0] rom [16];

    typedef struct packed {
        logic [7:0] ctl;     // {MB, MD, RW, MW, FS}
        logic [5:0] regs;    // {DA, AA, BA}
        logic [3:0] cst;
        logic [3:0] pc_next;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    control_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .AData     (AData),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .DA        (DA),
        .AA        (AA),
        .BA        (BA),
        .MB        (MB),
        .MD        (MD),
        .RW        (RW),
        .MW        (MW),
        .FS        (FS),
        .Constant  (Constant),
        .PC        (PC),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    // Synchronous instruction ROM: data valid one cycle after the address
    always_ff @(posedge CLK) begin
        imem_data <= rom[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference control table: {MB, MD, RW, MW, FS}
    function automatic logic [7:0] model_ctl(input logic [3:0] opc);
        case (opc)
            4'd1:    return 8'b0010_0000;
            4'd2:    return 8'b0010_0001;
            4'd3:    return 8'b0010_0010;
            4'd4:    return 8'b0010_0101;
            4'd5:    return 8'b0010_1000;
            4'd6:    return 8'b0010_1001;
            4'd7:    return 8'b0010_1010;
            4'd8:    return 8'b0010_1011;
            4'd9:    return 8'b1010_0111;
            4'd10:   return 8'b0110_0000;
            4'd11:   return 8'b0001_0000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // Runs one instruction; entered and left at the negedge of a FETCH cycle
    task automatic do_instr(input logic [3:0] opc, input logic [1:0] dr, input logic [1:0] sa,
                            input logic [1:0] sb, input logic [3:0] adata,
                            input logic [3:0] cur_pc, input logic [3:0] pc_next);
        exp_t e;
        rom[cur_pc] = {opc, dr, sa, sb};
        e.ctl     = model_ctl(opc);
        e.regs    = {dr, sa, sb};
        e.cst     = {2'b00, sb};
        e.pc_next = pc_next;
        sb_q.push_back(e);
        AData = adata;
        chk("fetch_addr", 32'(imem_addr), 32'(cur_pc));
        chk("fetch_ctl", 32'({MB, MD, RW, MW, FS}), 32'd0);
        chk("fetch_halted", 32'(halted), 32'd0);
        @(posedge CLK); @(negedge CLK);
        chk("decode_ctl", 32'({MB, MD, RW, MW, FS}), 32'd0);
        @(posedge CLK); @(negedge CLK);
        e = sb_q.pop_front();
        chk("exec_ctl", 32'({MB, MD, RW, MW, FS}), 32'(e.ctl));
        chk("exec_regs", 32'({DA, AA, BA}), 32'(e.regs));
        chk("exec_const", 32'(Constant), 32'(e.cst));
        chk("exec_pc", 32'(PC), 32'(cur_pc));
        @(posedge CLK); @(negedge CLK);
        chk("next_pc", 32'(PC), 32'(e.pc_next));
        chk("post_exec_ctl", 32'({MB, MD, RW, MW, FS}), 32'd0);
`ifdef SINGLE_STEP_EN
        if (opc != OPC_HALT) begin
            repeat (2) begin
                @(posedge CLK); @(negedge CLK);
                chk("step_idle_pc", 32'(PC), 32'(e.pc_next));
                chk("step_idle_ctl", 32'({MB, MD, RW, MW, FS}), 32'd0);
            end
            step = 1'b1;
            @(posedge CLK); @(negedge CLK);
            step = 1'b0;
        end
`endif
    endtask

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        AData = 4'd0;
`ifdef SINGLE_STEP_EN
        step  = 1'b0;
`endif
        for (int i = 0; i < 16; i++) rom[i] = 10'd0;

        // Reset, then idle with no start
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        repeat (10) begin @(posedge CLK); @(negedge CLK); end
        chk("idle_pc", 32'(PC), 32'd0);
        chk("idle_addr", 32'(imem_addr), 32'd0);
        chk("idle_ctl", 32'({MB, MD, RW, MW, FS}), 32'd0);
        chk("idle_regs", 32'({DA, AA, BA, Constant}), 32'd0);
        chk("idle_halted", 32'(halted), 32'd0);

        // Start: one cycle later the sequencer is fetching PC=0
        start = 1'b1;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0;

        do_instr(OPC_LDI, 2'd1, 2'd0, 2'd3, 4'd0, 4'd0, 4'd1);
        do_instr(OPC_ADD, 2'd2, 2'd1, 2'd1, 4'd0, 4'd1, 4'd2);
        do_instr(OPC_JMP, 2'd0, 2'd0, 2'd0, 4'd5, 4'd2, 4'd5);
        do_instr(OPC_BRZ, 2'b11, 2'd0, 2'b10, 4'd0, 4'd5, 4'd3);   // taken, -2
        do_instr(OPC_JMP, 2'd0, 2'd0, 2'd0, 4'd5, 4'd3, 4'd5);
        do_instr(OPC_BRZ, 2'b11, 2'd0, 2'b10, 4'd1, 4'd5, 4'd6);   // not taken
        do_instr(OPC_ST,  2'd0, 2'd1, 2'd2, 4'd0, 4'd6, 4'd7);
        do_instr(OPC_SUB, 2'd3, 2'd2, 2'd1, 4'd0, 4'd7, 4'd8);
        do_instr(OPC_LD,  2'd1, 2'd2, 2'd0, 4'd0, 4'd8, 4'd9);
        do_instr(OPC_JMP, 2'd0, 2'd0, 2'd0, 4'd10, 4'd9, 4'd10);
        do_instr(OPC_AND, 2'd1, 2'd2, 2'd3, 4'd0, 4'd10, 4'd11);
        do_instr(OPC_OR,  2'd2, 2'd3, 2'd0, 4'd0, 4'd11, 4'd12);
        do_instr(OPC_XOR, 2'd3, 2'd0, 2'd1, 4'd0, 4'd12, 4'd13);
        do_instr(OPC_NOT, 2'd0, 2'd1, 2'd2, 4'd0, 4'd13, 4'd14);
        do_instr(OPC_INC, 2'd1, 2'd1, 2'd0, 4'd0, 4'd14, 4'd15);
        do_instr(OPC_NOP, 2'd0, 2'd0, 2'd0, 4'd0, 4'd15, 4'd0);    // wrap 15 -> 0
        do_instr(OPC_MOV, 2'd3, 2'd2, 2'd1, 4'd0, 4'd0, 4'd1);
        do_instr(OPC_JMP, 2'd0, 2'd0, 2'd0, 4'd14, 4'd1, 4'd14);
        do_instr(OPC_BRN, 2'b00, 2'd1, 2'b11, 4'b1000, 4'd14, 4'd1); // +3 wraps
        do_instr(OPC_JMP, 2'd0, 2'd0, 2'd0, 4'd4, 4'd1, 4'd4);
        do_instr(OPC_BRN, 2'b00, 2'd1, 2'b11, 4'b0111, 4'd4, 4'd5);  // not taken
        do_instr(OPC_BRZ, 2'b10, 2'd0, 2'b00, 4'd0, 4'd5, 4'd13);    // -8 wraps
        do_instr(OPC_JMP, 2'd0, 2'd0, 2'd0, 4'd9, 4'd13, 4'd9);
        do_instr(OPC_HALT, 2'd0, 2'd0, 2'd0, 4'd0, 4'd9, 4'd9);

        // HALT holds: start ignored, PC frozen, no writes
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            @(posedge CLK); @(negedge CLK);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_pc", 32'(PC), 32'd9);
            chk("halt_rw_mw", 32'({RW, MW}), 32'd0);
        end
        start = 1'b0;

        // Reset in the middle of an ST execute cycle
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        rom[0] = {OPC_ST, 2'd0, 2'd1, 2'd2};
        start = 1'b1;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0;
        @(posedge CLK); @(negedge CLK);
        @(posedge CLK); @(negedge CLK);
        chk("st_exec_mw", 32'(MW), 32'd1);
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        chk("abort_mw", 32'(MW), 32'd0);
        chk("abort_rw", 32'(RW), 32'd0);
        chk("abort_pc", 32'(PC), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); @(negedge CLK);
            chk("abort_idle_mw", 32'(MW), 32'd0);
            chk("abort_idle_pc", 32'(PC), 32'd0);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
